// File: rtl/mem_access_unit.sv
// Load/store sequencer between the pipeline and the shared-memory arbiter.
// It handles one word-aligned access at a time, with a bounded wait for grant and ack.
//
// state | meaning
// IDLE  | waiting for a load/store strobe
// REQ   | requesting the bus, waiting for bus_gnt
// WAIT  | command on the bus, waiting for bus_ack
// DONE  | access complete, rdata_valid pulses for loads
// FAULT | misaligned, conflicting or timed-out access, err pulses
module mem_access_unit #(
  parameter int         ADDR_W  = 32,
  parameter int         DATA_W  = 32,
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              err,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] tmo_cnt;
  logic       strobe;
  logic       legal;
  logic       tmo_hit;

  assign strobe = memRead | memWrite;
  assign legal  = (memRead ^ memWrite) && (addr[1:0] == 2'b00);

  // Budget covers REQ and WAIT together; this cycle is the last one allowed.
  assign tmo_hit = ({1'b0, tmo_cnt} + 9'd1) >= {1'b0, TIMEOUT};

  assign stall = ((state == IDLE) && strobe) || (state == REQ) || (state == WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tmo_cnt     <= 8'd0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      bus_req     <= 1'b0;
      bus_valid   <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
    end else begin
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      case (state)
        IDLE: begin
          if (strobe) begin
            if (legal) begin
              bus_addr  <= addr;
              bus_wdata <= wdata;
              bus_we    <= memWrite;
              tmo_cnt   <= 8'd0;
              bus_req   <= 1'b1;
              state     <= REQ;
            end else begin
              err   <= 1'b1;
              state <= FAULT;
            end
          end
        end
        REQ: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (tmo_hit) begin
            bus_req <= 1'b0;
            err     <= 1'b1;
            state   <= FAULT;
          end else if (bus_gnt) begin
            bus_valid <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (bus_ack) begin
            bus_req   <= 1'b0;
            bus_valid <= 1'b0;
            if (!bus_we) begin
              rdata       <= bus_rdata;
              rdata_valid <= 1'b1;
            end
            state <= DONE;
          end else if (tmo_hit) begin
            bus_req   <= 1'b0;
            bus_valid <= 1'b0;
            err       <= 1'b1;
            state     <= FAULT;
          end
        end
        DONE:    state <= IDLE;
        FAULT:   state <= IDLE;
        default: begin
          bus_req   <= 1'b0;
          bus_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: per-transaction timeline model with a per-cycle compare
// thread, plus literal latency/fault checks that pin the model.
module tb_mem_access_unit;
  localparam int         AW = 32;
  localparam int         DW = 32;
  localparam logic [7:0] TMO = 8'd4;
  localparam int         T = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          memRead = 1'b0, memWrite = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          stall, rdata_valid, err, bus_req, bus_valid, bus_we;
  logic [DW-1:0] rdata, bus_wdata;
  logic [AW-1:0] bus_addr;
  logic          bus_gnt = 1'b0, bus_ack = 1'b0;
  logic [DW-1:0] bus_rdata = '0;

  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
    .rdata_valid(rdata_valid), .err(err), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // expected outputs for the current cycle
  logic          chk_en = 1'b0, exp_zero = 1'b1;
  logic          exp_stall = 0, exp_req = 0, exp_valid = 0, exp_rv = 0, exp_err = 0, exp_we = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0, exp_rdata = '0;

  // per-transaction observations of the DUT
  int cyc_idx = 0;
  int obs_stall, obs_rv_idx, obs_rv_cnt, obs_err_idx, obs_req_seen;
  logic [AW-1:0] obs_baddr;
  logic [DW-1:0] obs_bwdata;
  logic          obs_bwe;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
    n_checks++;
    if (act !== exv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exv, $time);
    end
  endtask

  task automatic compare();
    if (cyc_idx == 0) begin
      obs_stall = 0; obs_rv_idx = -1; obs_rv_cnt = 0; obs_err_idx = -1; obs_req_seen = 0;
    end
    if (stall) obs_stall++;
    if (rdata_valid) begin obs_rv_cnt++; if (obs_rv_idx < 0) obs_rv_idx = cyc_idx; end
    if (err && obs_err_idx < 0) obs_err_idx = cyc_idx;
    if (bus_req) obs_req_seen = 1;
    if (bus_valid) begin obs_baddr = bus_addr; obs_bwdata = bus_wdata; obs_bwe = bus_we; end
    if (!chk_en) return;
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("bus_req", 32'(bus_req), 32'(exp_req));
    chk("bus_valid", 32'(bus_valid), 32'(exp_valid));
    chk("rdata_valid", 32'(rdata_valid), 32'(exp_rv));
    chk("err", 32'(err), 32'(exp_err));
    chk("rdata", rdata, exp_rdata);
    if (exp_valid || exp_zero) begin
      chk("bus_we", 32'(bus_we), exp_zero ? 32'd0 : 32'(exp_we));
      chk("bus_addr", bus_addr, exp_zero ? 32'd0 : exp_addr);
      chk("bus_wdata", bus_wdata, exp_zero ? 32'd0 : exp_wdata);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cyc_idx++;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic gnt, input logic ack);
    memRead = rd; memWrite = wr; bus_gnt = gnt; bus_ack = ack;
    bus_rdata = $urandom;
  endtask

  task automatic expect_o(input logic st, input logic rq, input logic vl, input logic rv, input logic er);
    exp_stall = st; exp_req = rq; exp_valid = vl; exp_rv = rv; exp_err = er;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      addr = $urandom; wdata = $urandom;
      expect_o(0, 0, 0, 0, 0);
    end
  endtask

  // One access walked through its timeline. Grant arrives in REQ cycle g, ack in
  // WAIT cycle a; REQ+WAIT together may last at most T cycles unless the ack lands.
  task automatic run_txn(input logic rd, input logic wr, input logic [AW-1:0] a_in,
                         input logic [DW-1:0] wd, input int g, input int a,
                         input logic [DW-1:0] rdat);
    int n;
    logic legal;
    legal = (rd ^ wr) && (a_in[1:0] == 2'b00);
    exp_zero = 1'b0;
    exp_we = wr; exp_addr = a_in; exp_wdata = wd;
    cyc_idx = -1;
    tick();
    drive(rd, wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    addr = a_in; wdata = wd;
    expect_o(rd | wr, 0, 0, 0, 0);
    if (!legal) begin
      tick(); drive(0, 0, 0, 0); expect_o(0, 0, 0, 0, 1);
      return;
    end
    n = 0;
    for (int k = 0; ; k++) begin
      n++;
      tick(); drive(rd, wr, 1'(k == g), 1'($urandom_range(0, 1)));
      expect_o(1, 1, 0, 0, 0);
      if (n >= T) begin
        tick(); drive(0, 0, 0, 0); expect_o(0, 0, 0, 0, 1);
        return;
      end
      if (k == g) break;
    end
    for (int j = 0; ; j++) begin
      n++;
      tick(); drive(rd, wr, 1'($urandom_range(0, 1)), 1'(j == a));
      if (j == a) bus_rdata = rdat;
      expect_o(1, 1, 1, 0, 0);
      if (j == a) break;
      if (n >= T) begin
        tick(); drive(0, 0, 0, 0); expect_o(0, 0, 0, 0, 1);
        return;
      end
    end
    tick(); drive(0, 0, 0, 0);
    if (rd) exp_rdata = rdat;
    expect_o(0, 0, 0, rd, 0);
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    fork
      forever begin @(negedge clk); compare(); end
      begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    // reset state, checked before and during clocks
    #2;
    chk("rst bus_req", 32'(bus_req), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk_en = 1'b1; exp_zero = 1'b1;
    expect_o(0, 0, 0, 0, 0);
    #20 rst_n = 1'b1;
    idle(2);

    // load 0x100, immediate gnt, ack next cycle
    run_txn(1, 0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
    settle();
    chk("lat36 rv_idx", 32'(obs_rv_idx), 32'd3);
    chk("lat36 stall_cycles", 32'(obs_stall), 32'd3);
    chk("lat36 rdata", rdata, 32'hDEADBEEF);
    idle(1);

    // store 0x204, ack after 2 extra cycles
    run_txn(0, 1, 32'h204, 32'h12345678, 0, 2, 32'h0);
    settle();
    chk("st37 rv_cnt", 32'(obs_rv_cnt), 32'd0);
    chk("st37 bus_addr", obs_baddr, 32'h204);
    chk("st37 bus_wdata", obs_bwdata, 32'h12345678);
    chk("st37 bus_we", 32'(obs_bwe), 32'd1);
    idle(1);

    // misaligned load
    run_txn(1, 0, 32'h102, 32'h0, 0, 0, 32'h0);
    settle();
    chk("mis38 err_idx", 32'(obs_err_idx), 32'd1);
    chk("mis38 req_seen", 32'(obs_req_seen), 32'd0);
    chk("mis38 stall_cycles", 32'(obs_stall), 32'd1);
    idle(1);

    // grant never comes
    run_txn(1, 0, 32'h300, 32'h0, 99, 0, 32'h0);
    settle();
    chk("tmo39 err_idx", 32'(obs_err_idx), 32'd5);
    chk("tmo39 stall_cycles", 32'(obs_stall), 32'd5);
    chk("tmo39 rdata_kept", rdata, 32'hDEADBEEF);
    idle(1);

    // reset pulse in WAIT
    exp_zero = 1'b0; exp_we = 0; exp_addr = 32'h400; exp_wdata = 32'h55;
    tick(); drive(1, 0, 0, 0); addr = 32'h400; wdata = 32'h55; expect_o(1, 0, 0, 0, 0);
    tick(); drive(1, 0, 1, 0); expect_o(1, 1, 0, 0, 0);
    tick(); drive(1, 0, 0, 0); expect_o(1, 1, 1, 0, 0);
    #5;
    chk_en = 1'b0; memRead = 1'b0; rst_n = 1'b0;
    #1;
    chk("rst40 bus_req", 32'(bus_req), 32'd0);
    chk("rst40 bus_valid", 32'(bus_valid), 32'd0);
    chk("rst40 bus_addr", bus_addr, 32'd0);
    chk("rst40 rdata", rdata, 32'd0);
    #1 rst_n = 1'b1;
    exp_rdata = '0; exp_zero = 1'b1; expect_o(0, 0, 0, 0, 0); chk_en = 1'b1;
    idle(2);
    run_txn(1, 0, 32'h400, 32'h0, 1, 1, 32'hCAFEF00D);
    settle();
    chk("rst40 reload rv", 32'(obs_rv_cnt), 32'd1);

    // two back-to-back loads, then a spurious ack in IDLE
    run_txn(1, 0, 32'h500, 32'h0, 0, 0, 32'h11112222);
    settle();
    chk("b2b first rv", 32'(obs_rv_cnt), 32'd1);
    run_txn(1, 0, 32'h504, 32'h0, 1, 0, 32'h33334444);
    settle();
    chk("b2b second rv", 32'(obs_rv_cnt), 32'd1);
    tick(); drive(0, 0, 0, 1); expect_o(0, 0, 0, 0, 0);
    idle(1);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      int kind;
      logic [AW-1:0] ra;
      kind = $urandom_range(0, 9);
      ra = $urandom & ~32'h3;
      case (kind)
        0:       run_txn(1, 1, ra, $urandom, 0, 0, $urandom);
        1:       run_txn(1'($urandom_range(0, 1)), 1'b1, ra | 32'($urandom_range(1, 3)), $urandom, 0, 0, $urandom);
        2, 3, 4: run_txn(1, 0, ra, $urandom, $urandom_range(0, 4), $urandom_range(0, 3), $urandom);
        default: run_txn(0, 1, ra, $urandom, $urandom_range(0, 4), $urandom_range(0, 3), $urandom);
      endcase
      idle($urandom_range(0, 2));
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
